vstore_buf: RTL and testbench

Parametrised, in-order store buffer that succeeds the single-word versioned memory. Stores are allocated at dispatch in program order and filled out of order at execute. They are marked committed in order at retire and drained to data memory through a req/ack handshake. Younger loads receive per-byte store-to-load forwarding, and `flush` discards every uncommitted store. The block sits between the load/store unit and `dmem`.

---
 rtl/vstore_pkg.sv | 17 +
 rtl/vstore_fwd.sv | 59 +++++
 rtl/vstore_buf.sv | 134 +++++++++++++
 tb/tb_vstore_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vstore_pkg.sv
// Shared constants and helpers for the versioned store buffer.
// Pointers carry a wrap bit; ages are taken modulo 2*DEPTH.
package vstore_pkg;

    localparam logic [31:0]   RST_WORD = 32'hbeefdead;
    localparam logic [1023:0] RST_REP  = {32{RST_WORD}};

    // Distance from base to ptr on a w-bit wrapping pointer.
    function automatic logic [31:0] ptr_age(
        input logic [31:0] ptr,
        input logic [31:0] base,
        input int unsigned w
    );
        return (ptr - base) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/vstore_fwd.sv
// Store-to-load forwarding: per byte, the youngest candidate
// entry in [head, ld_tail) with a matching address wins.
module vstore_fwd
    import vstore_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int BE_W   = 4,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [BE_W-1:0]          ld_be,
    input  logic [IDX_W:0]           ld_tail,
    input  logic [IDX_W:0]           head,
    input  logic [DEPTH-1:0]         filled,
    input  logic [DEPTH*ADDR_W-1:0]  e_addr,
    input  logic [DEPTH*BE_W-1:0]    e_be,
    input  logic [DEPTH*BE_W*8-1:0]  e_data,
    output logic [BE_W-1:0]          ld_hit_be,
    output logic [BE_W*8-1:0]        ld_data,
    output logic                     ld_stall
);
    localparam int DW = BE_W * 8;

    logic [31:0]      span;
    logic [IDX_W-1:0] idx;
    logic             stall;

    always_comb begin
        ld_hit_be = '0;
        ld_data   = '0;
        stall     = 1'b0;
        idx       = '0;
        span      = ptr_age(32'(ld_tail), 32'(head), IDX_W + 1);
        // Walk oldest to youngest so younger matches overwrite.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head[IDX_W-1:0] + IDX_W'(k);
            if (32'(k) < span) begin
                if (!filled[idx])
                    stall = 1'b1;
                if (e_addr[idx*ADDR_W +: ADDR_W] == ld_addr) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (e_be[idx*BE_W + b] && ld_be[b]) begin
                            ld_hit_be[b]     = 1'b1;
                            ld_data[b*8 +: 8] = e_data[idx*DW + b*8 +: 8];
                        end
                    end
                end
            end
        end
        if (!ld_en || stall) begin
            ld_hit_be = '0;
            ld_data   = '0;
        end
        ld_stall = ld_en && stall;
    end

endmodule

// File: rtl/vstore_buf.sv
// In-order store buffer: alloc at dispatch, out-of-order fill,
// in-order commit, req/ack drain to dmem, per-byte forwarding.
module vstore_buf
    import vstore_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              alloc_en,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    output logic [IDX_W:0]    tail_ptr,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [BE_W-1:0]   fill_be,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              commit_en,
    output logic              commit_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BE_W-1:0]   ld_be,
    input  logic [IDX_W:0]    ld_tail,
    output logic [BE_W-1:0]   ld_hit_be,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              empty,
    output logic [IDX_W:0]    count
);
    localparam logic [DATA_W-1:0] RST_D = RST_REP[DATA_W-1:0];

    logic [IDX_W:0]           head, cmt, tail, cmt_nx;
    logic [DEPTH-1:0]         filled;
    logic [DEPTH*ADDR_W-1:0]  e_addr;
    logic [DEPTH*BE_W-1:0]    e_be;
    logic [DEPTH*DATA_W-1:0]  e_data;
    logic                     full, alloc_fire, fill_ok;
    logic                     commit_ok, drain;
    logic [IDX_W-1:0]         head_i, cmt_i, tail_i;

    assign head_i = head[IDX_W-1:0];
    assign cmt_i  = cmt[IDX_W-1:0];
    assign tail_i = tail[IDX_W-1:0];

    always_comb begin
        count       = tail - head;
        full        = (count == (IDX_W+1)'(DEPTH));
        empty       = (count == '0);
        alloc_ready = !full;
        alloc_idx   = tail_i;
        tail_ptr    = tail;
        alloc_fire  = alloc_en && !full && !flush;
        fill_ok     = fill_en && !flush &&
                      (ptr_age(32'(fill_idx), 32'(cmt_i), IDX_W) <
                       ptr_age(32'(tail), 32'(cmt), IDX_W + 1));
        commit_ok   = commit_en && (cmt != tail) && filled[cmt_i];
        cmt_nx      = cmt + (IDX_W+1)'(commit_ok);
        mem_req     = (head != cmt);
        drain       = mem_req && mem_ack;
        mem_addr    = '0;
        mem_be      = '0;
        mem_data    = '0;
        if (mem_req) begin
            mem_addr = e_addr[head_i*ADDR_W +: ADDR_W];
            mem_be   = e_be[head_i*BE_W +: BE_W];
            mem_data = e_data[head_i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head       <= '0;
            cmt        <= '0;
            tail       <= '0;
            commit_err <= 1'b0;
        end else begin
            head       <= head + (IDX_W+1)'(drain);
            cmt        <= cmt_nx;
            tail       <= flush ? cmt_nx : tail + (IDX_W+1)'(alloc_fire);
            commit_err <= commit_en && !commit_ok;
        end
    end

    // A fill only targets [cmt, tail), so it never races an alloc slot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            filled <= '0;
            e_addr <= '0;
            e_be   <= '0;
            e_data <= {DEPTH{RST_D}};
        end else begin
            if (alloc_fire)
                filled[tail_i] <= 1'b0;
            if (fill_ok) begin
                filled[fill_idx]                  <= 1'b1;
                e_addr[fill_idx*ADDR_W +: ADDR_W] <= fill_addr;
                e_be[fill_idx*BE_W +: BE_W]       <= fill_be;
                e_data[fill_idx*DATA_W +: DATA_W] <= fill_data;
            end
        end
    end

    vstore_fwd #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W),
        .IDX_W  (IDX_W)
    ) u_fwd (
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_be     (ld_be),
        .ld_tail   (ld_tail),
        .head      (head),
        .filled    (filled),
        .e_addr    (e_addr),
        .e_be      (e_be),
        .e_data    (e_data),
        .ld_hit_be (ld_hit_be),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall)
    );

endmodule

// File: tb/tb_vstore_buf.sv
// Directed bench for vstore_buf with a drain scoreboard.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))
module tb_vstore_buf;
    logic        clk = 1'b0;
    logic        nrst;
    logic        flush, alloc_en, alloc_ready;
    logic [2:0]  alloc_idx;
    logic [3:0]  tail_ptr;
    logic        fill_en;
    logic [2:0]  fill_idx;
    logic [15:0] fill_addr;
    logic [3:0]  fill_be;
    logic [31:0] fill_data;
    logic        commit_en, commit_err;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [3:0]  ld_be;
    logic [3:0]  ld_tail;
    logic [3:0]  ld_hit_be;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic        empty;
    logic [3:0]  count;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;
    wr_t q[$];

    int checks   = 0;
    int failures = 0;

    vstore_buf dut (
        .clk(clk), .nrst(nrst), .flush(flush),
        .alloc_en(alloc_en), .alloc_ready(alloc_ready),
        .alloc_idx(alloc_idx), .tail_ptr(tail_ptr),
        .fill_en(fill_en), .fill_idx(fill_idx),
        .fill_addr(fill_addr), .fill_be(fill_be),
        .fill_data(fill_data),
        .commit_en(commit_en), .commit_err(commit_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_tail(ld_tail), .ld_hit_be(ld_hit_be),
        .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_data(mem_data),
        .mem_ack(mem_ack), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        {flush, alloc_en, fill_en, commit_en, ld_en, mem_ack} = '0;
        fill_idx = '0; fill_addr = '0; fill_be = '0; fill_data = '0;
        ld_addr = '0; ld_be = '0; ld_tail = '0;
        q.delete();
        repeat (2) tick;
        nrst = 1'b1;
        tick;
    endtask

    task automatic alloc1;
        alloc_en = 1'b1;
        tick;
        alloc_en = 1'b0;
    endtask

    task automatic fill1(input logic [2:0] i, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        fill_en = 1'b1; fill_idx = i;
        fill_addr = a; fill_be = be; fill_data = d;
        tick;
        fill_en = 1'b0;
    endtask

    task automatic commit1(input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        wr_t w;
        w.a = a; w.be = be; w.d = d;
        q.push_back(w);
        commit_en = 1'b1;
        tick;
        commit_en = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] a, input logic [3:0] be,
                          input logic [3:0] t);
        ld_en = 1'b1; ld_addr = a; ld_be = be; ld_tail = t;
        #1;
    endtask

    task automatic drain_one;
        wr_t w;
        for (int c = 0; c < 20 && !mem_req; c++) tick;
        if (!mem_req || q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL drain_wait req=%0b queued=%0d", mem_req, q.size());
        end else begin
            w = q.pop_front();
            `CHK("drain_addr", mem_addr, w.a);
            `CHK("drain_be", mem_be, w.be);
            `CHK("drain_data", mem_data, w.d);
            mem_ack = 1'b1;
            tick;
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        do_reset;
        nrst = 1'b0;
        #1;
        `CHK("rst_ready", alloc_ready, 1);
        `CHK("rst_empty", empty, 1);
        `CHK("rst_count", count, 0);
        `CHK("rst_tail", tail_ptr, 0);
        `CHK("rst_idx", alloc_idx, 0);
        `CHK("rst_err", commit_err, 0);
        `CHK("rst_req", mem_req, 0);
        `CHK("rst_mdata", mem_data, 0);
        `CHK("rst_hit", ld_hit_be, 0);
        nrst = 1'b1;
        tick;

        // Fill to capacity, then one refused alloc.
        for (int i = 0; i < 8; i++) begin
            alloc_en = 1'b1;
            #1;
            `CHK("alloc_idx", alloc_idx, i);
            tick;
        end
        alloc_en = 1'b0;
        `CHK("full_count", count, 8);
        `CHK("full_ready", alloc_ready, 0);
        alloc1;
        `CHK("ovf_tail", tail_ptr, 4'd8);
        `CHK("ovf_count", count, 8);

        // Single store with a delayed ack.
        do_reset;
        alloc1;
        fill1(3'd0, 16'h10, 4'hf, 32'h11223344);
        commit1(16'h10, 4'hf, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            `CHK("hold_req", mem_req, 1);
            `CHK("hold_addr", mem_addr, 16'h10);
            `CHK("hold_data", mem_data, 32'h11223344);
            tick;
        end
        drain_one;
        `CHK("drained_empty", empty, 1);
        `CHK("drained_req", mem_req, 0);

        // Byte-merged forwarding from two stores.
        do_reset;
        alloc1;
        alloc1;
        fill1(3'd0, 16'h20, 4'b0011, 32'hAAAABBBB);
        fill1(3'd1, 16'h20, 4'b0110, 32'hCCCCDDDD);
        lookup(16'h20, 4'hf, 4'd2);
        `CHK("fwd2_hit", ld_hit_be, 4'b0111);
        `CHK("fwd2_data", ld_data, 32'h00CCDDBB);
        `CHK("fwd2_stall", ld_stall, 0);
        lookup(16'h20, 4'hf, 4'd1);
        `CHK("fwd1_hit", ld_hit_be, 4'b0011);
        `CHK("fwd1_data", ld_data, 32'h0000BBBB);
        lookup(16'h24, 4'hf, 4'd2);
        `CHK("fwd_miss", ld_hit_be, 0);
        ld_en = 1'b0;
        #1;
        `CHK("ld_off_hit", ld_hit_be, 0);
        `CHK("ld_off_data", ld_data, 0);
        commit1(16'h20, 4'b0011, 32'hAAAABBBB);
        commit1(16'h20, 4'b0110, 32'hCCCCDDDD);
        lookup(16'h20, 4'hf, 4'd2);
        `CHK("fwd_cmt_data", ld_data, 32'h00CCDDBB);
        ld_en = 1'b0;
        drain_one;
        drain_one;

        // Unfilled older store stalls a younger load.
        alloc1;
        alloc1;
        fill1(3'd3, 16'h30, 4'hf, 32'h55667788);
        lookup(16'h30, 4'hf, 4'd4);
        `CHK("stall_on", ld_stall, 1);
        `CHK("stall_hit", ld_hit_be, 0);
        lookup(16'h30, 4'hf, 4'd2);
        `CHK("stall_none", ld_stall, 0);
        ld_en = 1'b0;
        fill1(3'd2, 16'h40, 4'hf, 32'h12345678);
        lookup(16'h30, 4'hf, 4'd4);
        `CHK("stall_off", ld_stall, 0);
        `CHK("stall_fwd", ld_data, 32'h55667788);
        ld_en = 1'b0;

        // Flush keeps committed stores and drops the rest.
        do_reset;
        for (int i = 0; i < 5; i++) alloc1;
        for (int i = 0; i < 5; i++)
            fill1(3'(i), 16'(16'h50 + i), 4'hf, 32'(32'hA0 + i));
        commit1(16'h50, 4'hf, 32'hA0);
        commit1(16'h51, 4'hf, 32'hA1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        `CHK("flush_count", count, 2);
        `CHK("flush_tail", tail_ptr, 2);
        `CHK("flush_req", mem_req, 1);
        fill1(3'd3, 16'h99, 4'hf, 32'hDEAD0000);
        lookup(16'h99, 4'hf, 4'd4);
        `CHK("flushed_fill", ld_hit_be, 0);
        ld_en = 1'b0;
        commit_en = 1'b1;
        tick;
        commit_en = 1'b0;
        `CHK("flush_cerr", commit_err, 1);
        drain_one;
        drain_one;
        `CHK("flush_empty", empty, 1);

        // Rejected commits.
        do_reset;
        commit_en = 1'b1;
        tick;
        commit_en = 1'b0;
        `CHK("cerr_empty", commit_err, 1);
        tick;
        `CHK("cerr_pulse", commit_err, 0);
        alloc1;
        commit_en = 1'b1;
        tick;
        commit_en = 1'b0;
        `CHK("cerr_unfilled", commit_err, 1);
        `CHK("cerr_noreq", mem_req, 0);
        fill_en = 1'b1; fill_idx = 3'd0;
        fill_addr = 16'h60; fill_be = 4'hf; fill_data = 32'h0BADF00D;
        commit_en = 1'b1;
        tick;
        fill_en = 1'b0;
        commit_en = 1'b0;
        `CHK("cerr_samecyc", commit_err, 1);
        `CHK("cerr_same_req", mem_req, 0);
        commit1(16'h60, 4'hf, 32'h0BADF00D);
        `CHK("cmt_ok_err", commit_err, 0);
        drain_one;
        `CHK("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
